// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle RV32I controller and its datapath muxes.
package mc_pkg;

    // RV32I major opcodes handled by the controller
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11
    } state_e;

    // PC source select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JALR   = 2'b10;

    // ALU operand A select
    localparam logic [1:0] A_SRC_PC      = 2'b00;
    localparam logic [1:0] A_SRC_RS1     = 2'b01;
    localparam logic [1:0] A_SRC_OLDPC   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] B_SRC_RS2     = 2'b00;
    localparam logic [1:0] B_SRC_FOUR    = 2'b01;
    localparam logic [1:0] B_SRC_IMM     = 2'b10;

    // ALU operation class
    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

    // Register-file write-data select
    localparam logic [1:0] M2R_ALUOUT    = 2'b00;
    localparam logic [1:0] M2R_MDR       = 2'b01;
    localparam logic [1:0] M2R_PC        = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory signal bundle.
interface multicycle_control_if #(
    parameter int unsigned CNT_WIDTH = 32
);
    logic [6:0]           opcode;
    logic                 taken;
    logic                 mem_ready;
    logic                 mem_req;
    logic                 mem_read;
    logic                 mem_write;
    logic                 i_or_d;
    logic                 ir_write;
    logic                 old_pc_write;
    logic                 pc_write;
    logic [1:0]           pc_src;
    logic [1:0]           alu_src_a;
    logic [1:0]           alu_src_b;
    logic [1:0]           alu_op;
    logic                 reg_write;
    logic [1:0]           mem_to_reg;
    logic                 inst_done;
    logic                 illegal;
    logic [CNT_WIDTH-1:0] instret;

    modport master (
        input  opcode, taken, mem_ready,
        output mem_req, mem_read, mem_write, i_or_d, ir_write, old_pc_write,
               pc_write, pc_src, alu_src_a, alu_src_b, alu_op, reg_write,
               mem_to_reg, inst_done, illegal, instret
    );

    modport slave (
        output opcode, taken, mem_ready,
        input  mem_req, mem_read, mem_write, i_or_d, ir_write, old_pc_write,
               pc_write, pc_src, alu_src_a, alu_src_b, alu_op, reg_write,
               mem_to_reg, inst_done, illegal, instret
    );
endinterface

// File: rtl/mc_opcode_decode.sv
// Opcode dispatch used in DECODE: picks the next state or flags an illegal opcode.
module mc_opcode_decode
    import mc_pkg::*;
(
    input  logic [6:0] i_opcode,
    output state_e     o_next_state_c,
    output logic       o_illegal_c
);

    // Map supported opcodes to their first execute state; anything else returns to FETCH
    always_comb begin
        o_next_state_c = S_FETCH;
        o_illegal_c    = 1'b0;
        case (i_opcode)
            OP_R:      o_next_state_c = S_EXEC_R;
            OP_I:      o_next_state_c = S_EXEC_I;
            OP_LOAD,
            OP_STORE:  o_next_state_c = S_MEM_ADDR;
            OP_BRANCH: o_next_state_c = S_BRANCH;
            OP_JAL:    o_next_state_c = S_JAL;
            OP_JALR:   o_next_state_c = S_JALR;
            default:   o_illegal_c    = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: sequences the shared datapath and memory handshake.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    multicycle_control_if.master bus
);

    state_e               r_state;
    state_e               w_next_state;
    state_e               w_dec_next;
    logic                 w_dec_illegal;
    logic [CNT_WIDTH-1:0] r_instret;

    logic       w_mem_req, w_mem_read, w_mem_write, w_i_or_d;
    logic       w_ir_write, w_old_pc_write, w_pc_write, w_reg_write;
    logic       w_inst_done, w_illegal;
    logic [1:0] w_pc_src, w_alu_src_a, w_alu_src_b, w_alu_op, w_mem_to_reg;

    mc_opcode_decode u_dec (
        .i_opcode       (bus.opcode),
        .o_next_state_c (w_dec_next),
        .o_illegal_c    (w_dec_illegal)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) r_state <= S_FETCH;
        else       r_state <= w_next_state;
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk) begin
        if (!rstn)            r_instret <= '0;
        else if (w_inst_done) r_instret <= r_instret + CNT_WIDTH'(1);
    end

    // Next-state and control decode from the registered state
    always_comb begin
        w_next_state   = r_state;
        w_mem_req      = 1'b0;
        w_mem_read     = 1'b0;
        w_mem_write    = 1'b0;
        w_i_or_d       = 1'b0;
        w_ir_write     = 1'b0;
        w_old_pc_write = 1'b0;
        w_pc_write     = 1'b0;
        w_pc_src       = PC_SRC_ALU;
        w_alu_src_a    = A_SRC_PC;
        w_alu_src_b    = B_SRC_RS2;
        w_alu_op       = ALU_OP_ADD;
        w_reg_write    = 1'b0;
        w_mem_to_reg   = M2R_ALUOUT;
        w_inst_done    = 1'b0;
        w_illegal      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req   = 1'b1;
                w_mem_read  = 1'b1;
                w_alu_src_b = B_SRC_FOUR;
                if (bus.mem_ready) begin
                    w_ir_write     = 1'b1;
                    w_pc_write     = 1'b1;
                    w_old_pc_write = 1'b1;
                    w_next_state   = S_DECODE;
                end
            end
            S_DECODE: begin
                w_alu_src_a  = A_SRC_OLDPC;
                w_alu_src_b  = B_SRC_IMM;
                w_illegal    = w_dec_illegal;
                w_next_state = w_dec_next;
            end
            S_EXEC_R: begin
                w_alu_src_a  = A_SRC_RS1;
                w_alu_op     = ALU_OP_RTYPE;
                w_next_state = S_WB_ALU;
            end
            S_EXEC_I: begin
                w_alu_src_a  = A_SRC_RS1;
                w_alu_src_b  = B_SRC_IMM;
                w_alu_op     = ALU_OP_ITYPE;
                w_next_state = S_WB_ALU;
            end
            S_WB_ALU: begin
                w_reg_write  = 1'b1;
                w_inst_done  = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEM_ADDR: begin
                w_alu_src_a  = A_SRC_RS1;
                w_alu_src_b  = B_SRC_IMM;
                w_next_state = (bus.opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                w_mem_req  = 1'b1;
                w_mem_read = 1'b1;
                w_i_or_d   = 1'b1;
                if (bus.mem_ready) w_next_state = S_WB_MEM;
            end
            S_WB_MEM: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = M2R_MDR;
                w_inst_done  = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEM_WR: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                w_i_or_d    = 1'b1;
                if (bus.mem_ready) begin
                    w_inst_done  = 1'b1;
                    w_next_state = S_FETCH;
                end
            end
            S_BRANCH: begin
                w_alu_src_a  = A_SRC_RS1;
                w_alu_op     = ALU_OP_BRANCH;
                w_pc_src     = PC_SRC_ALUOUT;
                w_pc_write   = bus.taken;
                w_inst_done  = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JAL: begin
                w_pc_src     = PC_SRC_ALUOUT;
                w_pc_write   = 1'b1;
                w_reg_write  = 1'b1;
                w_mem_to_reg = M2R_PC;
                w_inst_done  = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JALR: begin
                w_alu_src_a  = A_SRC_RS1;
                w_alu_src_b  = B_SRC_IMM;
                w_pc_src     = PC_SRC_JALR;
                w_pc_write   = 1'b1;
                w_reg_write  = 1'b1;
                w_mem_to_reg = M2R_PC;
                w_inst_done  = 1'b1;
                w_next_state = S_FETCH;
            end
            default: w_next_state = S_FETCH;
        endcase
    end

    // All outputs forced low while reset is asserted so an in-flight request is abandoned at once
    assign bus.mem_req      = rstn & w_mem_req;
    assign bus.mem_read     = rstn & w_mem_read;
    assign bus.mem_write    = rstn & w_mem_write;
    assign bus.i_or_d       = rstn & w_i_or_d;
    assign bus.ir_write     = rstn & w_ir_write;
    assign bus.old_pc_write = rstn & w_old_pc_write;
    assign bus.pc_write     = rstn & w_pc_write;
    assign bus.reg_write    = rstn & w_reg_write;
    assign bus.inst_done    = rstn & w_inst_done;
    assign bus.illegal      = rstn & w_illegal;
    assign bus.pc_src       = rstn ? w_pc_src     : 2'b00;
    assign bus.alu_src_a    = rstn ? w_alu_src_a  : 2'b00;
    assign bus.alu_src_b    = rstn ? w_alu_src_b  : 2'b00;
    assign bus.alu_op       = rstn ? w_alu_op     : 2'b00;
    assign bus.mem_to_reg   = rstn ? w_mem_to_reg : 2'b00;
    assign bus.instret      = rstn ? r_instret    : '0;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle state/control checks with hand-computed vectors.
module tb_multicycle_control;
    import mc_pkg::*;

    logic clk;
    logic rstn;
    int   checks;
    int   failures;

    multicycle_control_if #(.CNT_WIDTH(32)) bus ();

    multicycle_control #(.CNT_WIDTH(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control outputs packed as {mem_req,mem_read,mem_write,i_or_d,ir_write,old_pc_write,
    // pc_write,pc_src,alu_src_a,alu_src_b,alu_op,reg_write,mem_to_reg,inst_done,illegal}
    logic [19:0] obs_ctl;
    assign obs_ctl = {bus.mem_req, bus.mem_read, bus.mem_write, bus.i_or_d, bus.ir_write,
                      bus.old_pc_write, bus.pc_write, bus.pc_src, bus.alu_src_a, bus.alu_src_b,
                      bus.alu_op, bus.reg_write, bus.mem_to_reg, bus.inst_done, bus.illegal};

    function automatic logic [19:0] ctl(input logic mreq, mrd, mwr, iod, irw, opw, pcw,
                                        input logic [1:0] pcs, asa, asb, aop,
                                        input logic rw, input logic [1:0] m2r,
                                        input logic done, ill);
        return {mreq, mrd, mwr, iod, irw, opw, pcw, pcs, asa, asb, aop, rw, m2r, done, ill};
    endfunction

    localparam logic [19:0] C_ZERO     = 20'h0;
    localparam logic [19:0] C_FETCH_GO = ctl(1,1,0,0,1,1,1, 2'b00,2'b00,2'b01,2'b00, 0,2'b00, 0,0);
    localparam logic [19:0] C_DECODE   = ctl(0,0,0,0,0,0,0, 2'b00,2'b10,2'b10,2'b00, 0,2'b00, 0,0);
    localparam logic [19:0] C_DEC_ILL  = ctl(0,0,0,0,0,0,0, 2'b00,2'b10,2'b10,2'b00, 0,2'b00, 0,1);
    localparam logic [19:0] C_EXEC_R   = ctl(0,0,0,0,0,0,0, 2'b00,2'b01,2'b00,2'b10, 0,2'b00, 0,0);
    localparam logic [19:0] C_WB_ALU   = ctl(0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,2'b00, 1,0);
    localparam logic [19:0] C_MEM_ADDR = ctl(0,0,0,0,0,0,0, 2'b00,2'b01,2'b10,2'b00, 0,2'b00, 0,0);
    localparam logic [19:0] C_MEM_RD   = ctl(1,1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,2'b00, 0,0);
    localparam logic [19:0] C_WB_MEM   = ctl(0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,2'b01, 1,0);
    localparam logic [19:0] C_MEM_WR   = ctl(1,0,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,2'b00, 0,0);
    localparam logic [19:0] C_BR_T     = ctl(0,0,0,0,0,0,1, 2'b01,2'b01,2'b00,2'b01, 0,2'b00, 1,0);
    localparam logic [19:0] C_BR_N     = ctl(0,0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b01, 0,2'b00, 1,0);
    localparam logic [19:0] C_JAL      = ctl(0,0,0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00, 1,2'b10, 1,0);
    localparam logic [19:0] C_JALR     = ctl(0,0,0,0,0,0,1, 2'b10,2'b01,2'b10,2'b00, 1,2'b10, 1,0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: let inputs settle, check state and controls, then advance past the edge
    task automatic cyc(input string tag, input state_e st, input logic [19:0] c);
        #1;
        chk({tag, "_state"}, 32'(dut.r_state), 32'(st));
        chk({tag, "_ctl"},   32'(obs_ctl),     32'(c));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        checks        = 0;
        failures      = 0;
        rstn          = 1'b0;
        bus.opcode    = 7'd0;
        bus.taken     = 1'b0;
        bus.mem_ready = 1'b0;

        // Reset: outputs all low, counter zero
        repeat (2) @(posedge clk);
        #1;
        cyc("rst", S_FETCH, C_ZERO);
        chk("rst_instret", bus.instret, 32'd0);

        // ADD with ready memory: 4 cycles
        rstn = 1'b1; bus.mem_ready = 1'b1; bus.opcode = OP_R;
        cyc("add_c1", S_FETCH,  C_FETCH_GO);
        cyc("add_c2", S_DECODE, C_DECODE);
        cyc("add_c3", S_EXEC_R, C_EXEC_R);
        chk("add_instret_before", bus.instret, 32'd0);
        cyc("add_c4", S_WB_ALU, C_WB_ALU);
        chk("add_instret", bus.instret, 32'd1);

        // LW with two wait cycles in MEM_RD
        bus.opcode = OP_LOAD;
        cyc("lw_c1", S_FETCH,    C_FETCH_GO);
        cyc("lw_c2", S_DECODE,   C_DECODE);
        cyc("lw_c3", S_MEM_ADDR, C_MEM_ADDR);
        bus.mem_ready = 1'b0;
        cyc("lw_c4", S_MEM_RD,   C_MEM_RD);
        cyc("lw_c5", S_MEM_RD,   C_MEM_RD);
        bus.mem_ready = 1'b1;
        cyc("lw_c6", S_MEM_RD,   C_MEM_RD);
        cyc("lw_c7", S_WB_MEM,   C_WB_MEM);
        chk("lw_instret", bus.instret, 32'd2);

        // BEQ taken then not taken
        bus.opcode = OP_BRANCH; bus.taken = 1'b1;
        cyc("beqt_c1", S_FETCH,  C_FETCH_GO);
        cyc("beqt_c2", S_DECODE, C_DECODE);
        cyc("beqt_c3", S_BRANCH, C_BR_T);
        bus.taken = 1'b0;
        cyc("beqn_c1", S_FETCH,  C_FETCH_GO);
        cyc("beqn_c2", S_DECODE, C_DECODE);
        cyc("beqn_c3", S_BRANCH, C_BR_N);
        chk("beq_instret", bus.instret, 32'd4);

        // JAL and JALR
        bus.opcode = OP_JAL;
        cyc("jal_c1", S_FETCH,  C_FETCH_GO);
        cyc("jal_c2", S_DECODE, C_DECODE);
        cyc("jal_c3", S_JAL,    C_JAL);
        bus.opcode = OP_JALR;
        cyc("jalr_c1", S_FETCH,  C_FETCH_GO);
        cyc("jalr_c2", S_DECODE, C_DECODE);
        cyc("jalr_c3", S_JALR,   C_JALR);
        chk("jalr_instret", bus.instret, 32'd6);

        // Illegal opcode: pulse in DECODE, back to FETCH, not retired
        bus.opcode = 7'b0000000;
        cyc("ill_c1", S_FETCH,  C_FETCH_GO);
        cyc("ill_c2", S_DECODE, C_DEC_ILL);
        #1;
        chk("ill_back_state", 32'(dut.r_state), 32'(S_FETCH));
        chk("ill_instret", bus.instret, 32'd6);

        // SW stalled in MEM_WR, then reset mid-access
        bus.opcode = OP_STORE;
        cyc("sw_c1", S_FETCH,    C_FETCH_GO);
        cyc("sw_c2", S_DECODE,   C_DECODE);
        cyc("sw_c3", S_MEM_ADDR, C_MEM_ADDR);
        bus.mem_ready = 1'b0;
        cyc("sw_c4", S_MEM_WR,   C_MEM_WR);
        cyc("sw_c5", S_MEM_WR,   C_MEM_WR);
        rstn = 1'b0;
        cyc("sw_rst", S_MEM_WR,  C_ZERO);
        chk("sw_rst_instret_out", bus.instret, 32'd0);
        chk("sw_rst_instret_reg", dut.r_instret, 32'd0);
        rstn = 1'b1; bus.mem_ready = 1'b1; bus.opcode = OP_R;
        cyc("post_rst_fetch", S_FETCH, C_FETCH_GO);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
